// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line and the receive-side outputs of uart_rx.
//   rx           serial input, idle high (driven by the line / bench)
//   received     one-cycle pulse, rx_byte holds a new good byte
//   rx_byte      last correctly framed byte
//   recv_error   one-cycle pulse on a framing error
//   is_receiving high while the receiver is not idle
// modport master: the receiver itself. modport slave: line driver / consumer.
interface uart_rx_if;
  logic       rx;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic       is_receiving;

  modport master (
    input  rx,
    output received,
    output rx_byte,
    output recv_error,
    output is_receiving
  );

  modport slave (
    output rx,
    input  received,
    input  rx_byte,
    input  recv_error,
    input  is_receiving
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line, no parity.
// Each bit is sampled once at mid-bit using a down-counter that is reloaded
// before it can underflow.
//   clock  system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    uart_rx_if.master: rx in; received, rx_byte, recv_error,
//          is_receiving out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to fall
// START     | counting half a bit to re-check the start bit at mid-bit
// DATA      | sampling 8 data bits, one per CLKS_PER_BIT at mid-bit
// STOP      | sampling the stop bit; good byte or framing error
// WAIT_IDLE | after a framing error, wait for the line to go high again
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // two-flop synchronizer; both stages reset to the idle level so a reset
  // never looks like a start edge
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             received_q, received_d;
  logic             recv_error_q, recv_error_d;
  logic             busy_q, busy_d;

  logic             cnt_done;

  assign cnt_done = (cnt_q == CNT_ZERO);

  always_comb begin
    sync1_d      = bus.rx;
    rx_s_d       = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end

      ST_START: begin
        if (cnt_done) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = 3'd0;
          end else begin
            // line was high again at mid-start: treat as a glitch
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DATA: begin
        if (cnt_done) begin
          // LSB arrives first, so new bits enter at the top and move down
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_STOP: begin
        if (cnt_done) begin
          // leaving at mid-stop-bit re-arms IDLE in time for a start bit
          // that follows with no idle gap
          if (rx_s_q) begin
            rx_byte_d  = shift_q;
            received_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            recv_error_d = 1'b1;
            state_d      = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT_IDLE: begin
        // a held-low line (break) must not be decoded as 0x00 bytes
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.received     = received_q;
  assign bus.rx_byte      = rx_byte_q;
  assign bus.recv_error   = recv_error_q;
  assign bus.is_receiving = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto uart_rx and checks its outputs against
// a frame-level model: every frame sent pushes its expected outcome (good
// byte or framing error) onto a queue that the output monitor consumes.
module tb_uart_rx;
  localparam int C = 8;
  localparam int H = C / 2;
  localparam int LAT = 2 + H + 9 * C + 1;  // pin fall to output pulse

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic rst_q = 1'b0;
  int   cyc = 0;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       exp_q[$];
  int         pulse_cyc[$];
  logic [7:0] last_good = 8'h00;
  int         busy_cnt = 0;
  exp_t       e;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (rst_q) begin
      last_good = 8'h00;
      check_val("rst_received", int'(u_if.received), 0);
      check_val("rst_recv_error", int'(u_if.recv_error), 0);
      check_val("rst_rx_byte", int'(u_if.rx_byte), 0);
      check_val("rst_is_receiving", int'(u_if.is_receiving), 0);
    end else begin
      if (u_if.received || u_if.recv_error) begin
        check_val("pulse_exclusive", int'(u_if.received & u_if.recv_error), 0);
        pulse_cyc.push_back(cyc);
        check_val("pulse_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("pulse_kind_err", int'(u_if.recv_error), int'(e.err));
          if (!e.err) last_good = e.data;
        end
      end
      check_val("rx_byte", int'(u_if.rx_byte), int'(last_good));
      if (u_if.is_receiving === 1'b1) busy_cnt++;
    end
  end

  task automatic drive_bit(input logic v, input int len);
    u_if.rx = v;
    repeat (len) @(negedge clock);
  endtask

  // stretch: bit lengths alternate C, C+1 starting with the start bit,
  // i.e. a sender running about 6% slow
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit stretch,
                            input int hold_low, output int fall);
    exp_t x;
    x.err  = !stop;
    x.data = d;
    exp_q.push_back(x);
    fall = cyc;
    drive_bit(1'b0, C);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (stretch && (i % 2 == 0)) ? C + 1 : C);
    drive_bit(stop, stretch ? C + 1 : C);
    if (!stop) repeat (hold_low) @(negedge clock);
    u_if.rx = 1'b1;
  endtask

  int         f, f1, f2, n_before;
  logic [7:0] d;
  bit         rerr;
  int         gap;

  initial begin
    u_if.rx = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: single frame, exact latency
    pulse_cyc.delete();
    send_frame(8'hA5, 1'b1, 1'b0, 0, f);
    repeat (6) @(negedge clock);
    check_val("t1_pulse_count", pulse_cyc.size(), 1);
    if (pulse_cyc.size() > 0) check_val("t1_latency", pulse_cyc[0], f + LAT);
    check_val("t1_byte", int'(u_if.rx_byte), 8'hA5);

    // 2: two-cycle glitch
    pulse_cyc.delete();
    busy_cnt = 0;
    u_if.rx = 1'b0;
    repeat (2) @(negedge clock);
    u_if.rx = 1'b1;
    repeat (20) @(negedge clock);
    check_val("t2_no_pulse", pulse_cyc.size(), 0);
    check_val("t2_busy_len_ok", int'(busy_cnt >= H - 1 && busy_cnt <= H + 1), 1);
    check_val("t2_byte_kept", int'(u_if.rx_byte), 8'hA5);

    // 3: framing error then recovery
    pulse_cyc.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 30, f);
    check_val("t3_busy_while_low", int'(u_if.is_receiving), 1);
    repeat (6) @(negedge clock);
    check_val("t3_idle_after_high", int'(u_if.is_receiving), 0);
    check_val("t3_pulse_count", pulse_cyc.size(), 1);
    check_val("t3_byte_kept", int'(u_if.rx_byte), 8'hA5);
    send_frame(8'h3C, 1'b1, 1'b0, 0, f);
    repeat (4) @(negedge clock);
    check_val("t3_byte_good", int'(u_if.rx_byte), 8'h3C);

    // 4: back-to-back frames with zero gap
    pulse_cyc.delete();
    send_frame(8'h12, 1'b1, 1'b0, 0, f1);
    send_frame(8'h34, 1'b1, 1'b0, 0, f2);
    send_frame(8'hFF, 1'b1, 1'b0, 0, f);
    repeat (6) @(negedge clock);
    check_val("t4_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      check_val("t4_first", pulse_cyc[0], f1 + LAT);
      check_val("t4_gap1", pulse_cyc[1] - pulse_cyc[0], 10 * C);
      check_val("t4_gap2", pulse_cyc[2] - pulse_cyc[1], 10 * C);
    end
    check_val("t4_byte", int'(u_if.rx_byte), 8'hFF);

    // 5: reset during data bit 3 of 0x5A; the sender abandons the frame
    pulse_cyc.delete();
    d = 8'h5A;
    drive_bit(1'b0, C);
    for (int i = 0; i < 3; i++) drive_bit(d[i], C);
    drive_bit(d[3], H);
    reset = 1'b1;
    u_if.rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("t5_busy_after_rst", int'(u_if.is_receiving), 0);
    check_val("t5_byte_after_rst", int'(u_if.rx_byte), 0);
    repeat (20) @(negedge clock);
    check_val("t5_no_pulse", pulse_cyc.size(), 0);
    send_frame(8'hC3, 1'b1, 1'b0, 0, f);
    repeat (4) @(negedge clock);
    check_val("t5_byte", int'(u_if.rx_byte), 8'hC3);

    // 6: slow sender
    send_frame(8'h81, 1'b1, 1'b1, 0, f);
    repeat (4) @(negedge clock);
    check_val("t6_byte", int'(u_if.rx_byte), 8'h81);

    // randomized frames, gaps and framing errors
    n_before = 0;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom_range(0, 255));
      rerr = ($urandom_range(0, 4) == 0);
      gap  = $urandom_range(0, 12);
      send_frame(d, !rerr, 1'b0, rerr ? $urandom_range(1, 20) : 0, f);
      if (rerr) n_before++;
      repeat (rerr ? gap + 2 : gap) @(negedge clock);
    end
    repeat (10) @(negedge clock);
    check_val("rand_all_outcomes_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
